friscv_mem_rd_arbiter: RTL and testbench

FRISCV_MEM_RD_ARBITER -- requirements
Module: friscv_mem_rd_arbiter

---
 rtl/friscv_mem_rd_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_friscv_mem_rd_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_mem_rd_arbiter.sv
// friscv_mem_rd_arbiter: merges the icache (s0) and dcache (s1) AXI read
// channels onto one memory read port and routes R bursts back in AR order.
//
// Ports:
//   aclk, srst          clock, synchronous active-high reset
//   s0_ar*, s0_r*       requester 0 (icache memctrl) AR / R channels
//   s1_ar*, s1_r*       requester 1 (dcache memctrl) AR / R channels
//   m_ar*, m_r*         shared memory AR / R channels
//   idle                no AR pending and no burst outstanding
//
// Configuration macro:
//   FRISCV_RDARB_RR_EN  defined: round-robin arbitration between s0/s1
//                       undefined: fixed priority, s1 always wins over s0
//
// An owner FIFO records which requester won each accepted AR. Memory
// returns bursts in AR order, so the FIFO head names the R destination.

module friscv_mem_rd_arbiter #(
   parameter int AXI_ADDR_W  = 32,
   parameter int AXI_ID_W    = 8,
   parameter int AXI_DATA_W  = 128,
   parameter int OSTDREQ_NUM = 8
) (
   input  logic                  aclk,
   input  logic                  srst,
   // requester 0 (icache)
   input  logic                  s0_arvalid,
   output logic                  s0_arready,
   input  logic [AXI_ADDR_W-1:0] s0_araddr,
   input  logic [7:0]            s0_arlen,
   input  logic [AXI_ID_W-1:0]   s0_arid,
   output logic                  s0_rvalid,
   input  logic                  s0_rready,
   output logic [AXI_ID_W-1:0]   s0_rid,
   output logic [1:0]            s0_rresp,
   output logic [AXI_DATA_W-1:0] s0_rdata,
   output logic                  s0_rlast,
   // requester 1 (dcache)
   input  logic                  s1_arvalid,
   output logic                  s1_arready,
   input  logic [AXI_ADDR_W-1:0] s1_araddr,
   input  logic [7:0]            s1_arlen,
   input  logic [AXI_ID_W-1:0]   s1_arid,
   output logic                  s1_rvalid,
   input  logic                  s1_rready,
   output logic [AXI_ID_W-1:0]   s1_rid,
   output logic [1:0]            s1_rresp,
   output logic [AXI_DATA_W-1:0] s1_rdata,
   output logic                  s1_rlast,
   // memory side
   output logic                  m_arvalid,
   input  logic                  m_arready,
   output logic [AXI_ADDR_W-1:0] m_araddr,
   output logic [7:0]            m_arlen,
   output logic [AXI_ID_W-1:0]   m_arid,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   input  logic [AXI_ID_W-1:0]   m_rid,
   input  logic [1:0]            m_rresp,
   input  logic [AXI_DATA_W-1:0] m_rdata,
   input  logic                  m_rlast,
   // status
   output logic                  idle
);

   localparam int PW = $clog2(OSTDREQ_NUM);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   typedef enum logic {
      ST_ARB,
      ST_LOCK
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   grant_q;
   logic                   grant_d;
   logic [PW:0]            wr_ptr_q;
   logic [PW:0]            wr_ptr_d;
   logic [PW:0]            rd_ptr_q;
   logic [PW:0]            rd_ptr_d;
   logic [OSTDREQ_NUM-1:0] owner_q;
   logic [OSTDREQ_NUM-1:0] owner_d;

   logic fifo_full;
   logic fifo_empty;
   logic head;
   logic arb_pick;
   logic sel;
   logic sel_vld;
   logic ar_go;
   logic ar_push;
   logic r_route;
   logic r_pop;

   // ---------------------------------------------------------------
   // Owner FIFO status
   // ---------------------------------------------------------------
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      head       = owner_q[rd_ptr_q[PW-1:0]];
   end

   // ---------------------------------------------------------------
   // Winner choice while no grant is held
   // ---------------------------------------------------------------
`ifdef FRISCV_RDARB_RR_EN
   logic rr_q;
   logic rr_d;

   always_comb begin
      arb_pick = s1_arvalid;
      if (s0_arvalid && s1_arvalid) begin
         arb_pick = rr_q;
      end
   end

   // Priority moves to the requester that did not just win.
   always_comb begin
      rr_d = rr_q;
      if (ar_push) begin
         rr_d = ~sel;
      end
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   // s1 wins whenever it asks; s0 only when s1 is quiet.
   always_comb begin
      arb_pick = s1_arvalid;
   end
`endif

   // ---------------------------------------------------------------
   // AR path: selected requester straight through, no added latency
   // ---------------------------------------------------------------
   always_comb begin
      sel     = (state_q == ST_LOCK) ? grant_q : arb_pick;
      sel_vld = sel ? s1_arvalid : s0_arvalid;
      ar_go   = sel_vld && !fifo_full && !srst;
      ar_push = ar_go && m_arready;

      m_arvalid  = ar_go;
      m_araddr   = sel ? s1_araddr : s0_araddr;
      m_arlen    = sel ? s1_arlen  : s0_arlen;
      m_arid     = sel ? s1_arid   : s0_arid;
      s0_arready = ar_push && !sel;
      s1_arready = ar_push && sel;
   end

   // Hold the grant while an offered AR waits, so the memory side sees
   // a stable request until it is accepted.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         ST_ARB: begin
            if (ar_go && !m_arready) begin
               state_d = ST_LOCK;
               grant_d = sel;
            end
         end
         ST_LOCK: begin
            if (m_arready) begin
               state_d = ST_ARB;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // R path: FIFO head selects the destination requester
   // ---------------------------------------------------------------
   always_comb begin
      r_route   = !fifo_empty && !srst;
      s0_rvalid = m_rvalid && r_route && !head;
      s1_rvalid = m_rvalid && r_route && head;
      m_rready  = r_route && (head ? s1_rready : s0_rready);
      r_pop     = m_rvalid && m_rready && m_rlast;

      s0_rid   = m_rid;
      s0_rresp = m_rresp;
      s0_rdata = m_rdata;
      s0_rlast = m_rlast;
      s1_rid   = m_rid;
      s1_rresp = m_rresp;
      s1_rdata = m_rdata;
      s1_rlast = m_rlast;

      idle = srst || (!m_arvalid && fifo_empty);
   end

   // ---------------------------------------------------------------
   // Owner FIFO update; push and pop may happen in the same cycle
   // ---------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      owner_d  = owner_q;
      if (ar_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         owner_d[wr_ptr_q[PW-1:0]] = sel;
      end
      if (r_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge aclk) begin
      if (srst) begin
         state_q  <= ST_ARB;
         grant_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entries are only read between push and pop, so no reset needed.
   always_ff @(posedge aclk) begin
      owner_q <= owner_d;
   end

endmodule

// File: tb/tb_friscv_mem_rd_arbiter.sv
// tb_friscv_mem_rd_arbiter: directed scenarios plus randomized traffic
// against an ordered-ownership reference model.

module tb_friscv_mem_rd_arbiter;

   localparam int AW = 32;
   localparam int IW = 8;
   localparam int DW = 128;
   localparam int N  = 8;

   logic          aclk = 1'b0;
   logic          srst;
   logic          s0_arvalid, s0_arready, s0_rvalid, s0_rready, s0_rlast;
   logic [AW-1:0] s0_araddr;
   logic [7:0]    s0_arlen;
   logic [IW-1:0] s0_arid, s0_rid;
   logic [1:0]    s0_rresp;
   logic [DW-1:0] s0_rdata;
   logic          s1_arvalid, s1_arready, s1_rvalid, s1_rready, s1_rlast;
   logic [AW-1:0] s1_araddr;
   logic [7:0]    s1_arlen;
   logic [IW-1:0] s1_arid, s1_rid;
   logic [1:0]    s1_rresp;
   logic [DW-1:0] s1_rdata;
   logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [AW-1:0] m_araddr;
   logic [7:0]    m_arlen;
   logic [IW-1:0] m_arid, m_rid;
   logic [1:0]    m_rresp;
   logic [DW-1:0] m_rdata;
   logic          idle;

   always #5 aclk = ~aclk;

   friscv_mem_rd_arbiter #(
      .AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW), .OSTDREQ_NUM(N)
   ) dut (
      .aclk(aclk), .srst(srst),
      .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
      .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arid(s0_arid),
      .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rid(s0_rid),
      .s0_rresp(s0_rresp), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast),
      .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
      .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arid(s1_arid),
      .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rid(s1_rid),
      .s1_rresp(s1_rresp), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
      .m_rresp(m_rresp), .m_rdata(m_rdata), .m_rlast(m_rlast),
      .idle(idle)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: ordered list of owners of outstanding bursts,
   // an optionally pending (locked) offer, and the priority pointer.
   bit own_q[$];
   bit lk;
   bit lk_req;
   bit rr;

   // Stimulus bookkeeping from observed handshakes.
   bit acc0, acc1, r_acc;
   int mem_q[$];
   int beat;

   always @(negedge aclk) begin
      bit full, empty, req, offer, ex_arv, hd, ex_rg, ex_rr;
      full  = (own_q.size() == N);
      empty = (own_q.size() == 0);
      if (lk) req = lk_req;
      else if (s0_arvalid && s1_arvalid) begin
`ifdef FRISCV_RDARB_RR_EN
         req = rr;
`else
         req = 1'b1;
`endif
      end else req = s1_arvalid;
      offer  = req ? s1_arvalid : s0_arvalid;
      ex_arv = !srst && offer && !full;
      chk("m_arvalid", m_arvalid, ex_arv);
      chk("s0_arready", s0_arready, ex_arv && m_arready && !req);
      chk("s1_arready", s1_arready, ex_arv && m_arready && req);
      if (ex_arv) begin
         chk("m_araddr", m_araddr, req ? s1_araddr : s0_araddr);
         chk("m_arlen", m_arlen, req ? s1_arlen : s0_arlen);
         chk("m_arid", m_arid, req ? s1_arid : s0_arid);
      end
      hd    = empty ? 1'b0 : own_q[0];
      ex_rg = !srst && !empty;
      ex_rr = ex_rg && (hd ? s1_rready : s0_rready);
      chk("s0_rvalid", s0_rvalid, ex_rg && m_rvalid && !hd);
      chk("s1_rvalid", s1_rvalid, ex_rg && m_rvalid && hd);
      chk("m_rready", m_rready, ex_rr);
      if (ex_rg && m_rvalid) begin
         chk("r_data", hd ? s1_rdata : s0_rdata, m_rdata);
         chk("r_id", hd ? s1_rid : s0_rid, m_rid);
         chk("r_resp", hd ? s1_rresp : s0_rresp, m_rresp);
         chk("r_last", hd ? s1_rlast : s0_rlast, m_rlast);
      end
      chk("idle", idle, srst || (!ex_arv && empty));

      if (srst) begin
         own_q.delete();
         lk = 0;
         rr = 0;
      end else begin
         if (ex_rr && m_rvalid && m_rlast) void'(own_q.pop_front());
         if (ex_arv && m_arready) begin
            own_q.push_back(req);
            lk = 0;
            rr = !req;
         end else if (ex_arv) begin
            lk = 1;
            lk_req = req;
         end
      end

      acc0  = s0_arvalid && s0_arready;
      acc1  = s1_arvalid && s1_arready;
      r_acc = m_rvalid && m_rready;
      if (srst) begin
         mem_q.delete();
         beat = 0;
      end else begin
         if (r_acc && mem_q.size() > 0) begin
            if (m_rlast) begin
               void'(mem_q.pop_front());
               beat = 0;
            end else beat++;
         end
         if (m_arvalid && m_arready) mem_q.push_back(int'(m_arlen));
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic issue(input bit s, input logic [AW-1:0] a,
                        input logic [IW-1:0] id, input logic [7:0] len);
      int k;
      m_arready = 1'b1;
      if (s) begin
         s1_arvalid = 1; s1_araddr = a; s1_arid = id; s1_arlen = len;
      end else begin
         s0_arvalid = 1; s0_araddr = a; s0_arid = id; s0_arlen = len;
      end
      for (k = 0; k < 20; k++) begin
         @(negedge aclk);
         if (s ? s1_arready : s0_arready) break;
         tick();
      end
      chk("issue_timeout", k < 20, 1'b1);
      tick();
      if (s) s1_arvalid = 0;
      else s0_arvalid = 0;
   endtask

   task automatic drain();
      int k;
      s0_rready = 1; s1_rready = 1;
      m_rvalid = 1; m_rlast = 1;
      for (k = 0; k < 40; k++) begin
         @(negedge aclk);
         if (idle) break;
         tick();
      end
      chk("drain_timeout", k < 40, 1'b1);
      tick();
      m_rvalid = 0; m_rlast = 0;
   endtask

   initial begin
      bit w, e1;
      srst = 1;
      s0_arvalid = 1; s0_araddr = '0; s0_arlen = '0; s0_arid = '0;
      s1_arvalid = 0; s1_araddr = '0; s1_arlen = '0; s1_arid = '0;
      s0_rready = 1; s1_rready = 1;
      m_arready = 1; m_rvalid = 0; m_rid = '0; m_rresp = '0;
      m_rdata = '0; m_rlast = 0;

      // Reset: outputs gated even with traffic on the inputs.
      tick();
      @(negedge aclk);
      chk("rst_m_arvalid", m_arvalid, 1'b0);
      chk("rst_s0_arready", s0_arready, 1'b0);
      chk("rst_m_rready", m_rready, 1'b0);
      chk("rst_idle", idle, 1'b1);
      tick();
      s0_arvalid = 0;
      tick();
      srst = 0;

      // Arbitration policy with both requesters asking every cycle.
      s0_arvalid = 1; s0_araddr = 32'hA0; s0_arid = 8'd1;
      s1_arvalid = 1; s1_araddr = 32'hB0; s1_arid = 8'd2;
      m_arready = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
`ifdef FRISCV_RDARB_RR_EN
         w = (i % 2) == 1;
`else
         w = 1'b1;
`endif
         chk("pol_s0_arready", s0_arready, !w);
         chk("pol_s1_arready", s1_arready, w);
         chk("pol_m_araddr", m_araddr, w ? 32'hB0 : 32'hA0);
         chk("pol_m_arid", m_arid, w ? 8'd2 : 8'd1);
         tick();
      end
      s1_arvalid = 0;
      @(negedge aclk);
      chk("pol_s0_after", s0_arready, 1'b1);
      tick();
      s0_arvalid = 0;
      drain();

      // Locked AR held stable while memory stalls.
      s0_arvalid = 1; s0_araddr = 32'h100; s0_arlen = 8'd3; s0_arid = 8'd5;
      m_arready = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         chk("lock_m_araddr", m_araddr, 32'h100);
         chk("lock_m_arlen", m_arlen, 8'd3);
         chk("lock_s1_arready", s1_arready, 1'b0);
         tick();
         s1_arvalid = 1; s1_araddr = 32'h180; s1_arlen = 8'd0;
      end
      m_arready = 1;
      @(negedge aclk);
      chk("lock_s0_arready", s0_arready, 1'b1);
      chk("lock_s1_wait", s1_arready, 1'b0);
      tick();
      s0_arvalid = 0;
      @(negedge aclk);
      chk("lock_s1_next", s1_arready, 1'b1);
      tick();
      s1_arvalid = 0;
      drain();

      // In-order routing with backpressure.
      issue(1, 32'h200, 8'd10, 8'd1);
      issue(0, 32'h300, 8'd11, 8'd1);
      issue(1, 32'h400, 8'd12, 8'd1);
      for (int b = 1; b <= 6; b++) begin
         m_rvalid = 1; m_rdata = DW'(b); m_rid = IW'(b);
         m_rlast = (b % 2) == 0;
         if (b == 3) begin
            s0_rready = 0;
            @(negedge aclk);
            chk("bp_m_rready", m_rready, 1'b0);
            chk("bp_s0_rvalid", s0_rvalid, 1'b1);
            tick();
            s0_rready = 1;
         end
         @(negedge aclk);
         e1 = (b <= 2) || (b >= 5);
         chk("route_s1_rvalid", s1_rvalid, e1);
         chk("route_s0_rvalid", s0_rvalid, !e1);
         chk("route_m_rready", m_rready, 1'b1);
         chk("route_data", e1 ? s1_rdata : s0_rdata, DW'(b));
         tick();
      end
      m_rvalid = 0; m_rlast = 0;
      @(negedge aclk);
      chk("route_idle", idle, 1'b1);
      tick();

      // Full FIFO blocks the ninth AR until a burst completes.
      for (int i = 0; i < 8; i++)
         issue(0, 32'h1000 + 32'(i * 16), IW'(i), 8'd0);
      s0_arvalid = 1; s0_araddr = 32'h2000; s0_arid = 8'd9; s0_arlen = 8'd0;
      m_arready = 1;
      @(negedge aclk);
      chk("full_m_arvalid", m_arvalid, 1'b0);
      chk("full_s0_arready", s0_arready, 1'b0);
      chk("full_idle", idle, 1'b0);
      tick();
      m_rvalid = 1; m_rlast = 1;
      @(negedge aclk);
      chk("full_pop_m_rready", m_rready, 1'b1);
      chk("full_pop_m_arvalid", m_arvalid, 1'b0);
      tick();
      m_rvalid = 0; m_rlast = 0;
      @(negedge aclk);
      chk("full_9th_m_arvalid", m_arvalid, 1'b1);
      chk("full_9th_s0_arready", s0_arready, 1'b1);
      chk("full_9th_m_araddr", m_araddr, 32'h2000);
      tick();
      s0_arvalid = 0;

      // Reset with bursts outstanding drops ownership.
      srst = 1;
      tick();
      srst = 0;
      @(negedge aclk);
      chk("rst_mid_idle", idle, 1'b1);
      chk("rst_mid_m_rready", m_rready, 1'b0);
      tick();
      issue(0, 32'h3000, 8'd7, 8'd0);
      drain();

      // Randomized traffic with a well-behaved memory model.
      srst = 1;
      tick();
      srst = 0;
      for (int c = 0; c < 3000; c++) begin
         srst = ($urandom_range(0, 599) == 0);
         if (!s0_arvalid || acc0) begin
            s0_arvalid = $urandom_range(0, 2) != 0;
            s0_araddr = $urandom;
            s0_arlen = 8'($urandom_range(0, 3));
            s0_arid = 8'($urandom);
         end
         if (!s1_arvalid || acc1) begin
            s1_arvalid = $urandom_range(0, 2) != 0;
            s1_araddr = $urandom;
            s1_arlen = 8'($urandom_range(0, 3));
            s1_arid = 8'($urandom);
         end
         m_arready = $urandom_range(0, 9) < 7;
         s0_rready = $urandom_range(0, 3) != 0;
         s1_rready = $urandom_range(0, 3) != 0;
         if (mem_q.size() == 0) begin
            m_rvalid = 0;
            m_rlast = 0;
         end else if (m_rvalid && !r_acc) begin
            m_rvalid = 1;
         end else if ($urandom_range(0, 9) < 7) begin
            m_rvalid = 1;
            m_rdata = {$urandom, $urandom, $urandom, $urandom};
            m_rid = 8'($urandom);
            m_rresp = 2'($urandom);
            m_rlast = (beat >= mem_q[0]);
         end else begin
            m_rvalid = 0;
         end
         tick();
      end
      srst = 0;
      s0_arvalid = 0; s1_arvalid = 0; m_rvalid = 0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
